button_reader: RTL and testbench

- Input-side counterpart of the LED output drivers: reads up to 8 raw board buttons/switches.
- Synchronises and debounces each input and exposes stable levels.
- Queues press/release events in a small FIFO with a valid/ready handshake, for pattern/speed control logic downstream.
- Sits between board pins and user control FSMs in the same clock domain as the LED drivers.

---
 rtl/button_reader.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_button_reader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_reader.sv
// button_reader: synchronises and debounces up to 8 raw buttons and queues press/release events.
// Define BUTTON_READER_LONG_PRESS_EN to add long-press events, the LONG_CYCLES parameter and evt_long.
module button_reader #(
    parameter int N_IN            = 8,
    parameter int DEBOUNCE_CYCLES = 125000,
`ifdef BUTTON_READER_LONG_PRESS_EN
    parameter int LONG_CYCLES     = 125000000,
`endif
    parameter int FIFO_DEPTH      = 4
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic [N_IN-1:0] btn_in,
    output logic [N_IN-1:0] btn_state,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [3:0]      evt_code,
`ifdef BUTTON_READER_LONG_PRESS_EN
    output logic            evt_long,
`endif
    output logic            evt_overflow
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;
`ifdef BUTTON_READER_LONG_PRESS_EN
    localparam int ENTRY_W = 5;
    localparam int HOLD_W  = $clog2(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
`else
    localparam int ENTRY_W = 4;
`endif

    if (N_IN < 1 || N_IN > 8) begin : g_bad_n_in
        $error("button_reader: N_IN must be 1..8");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_reader: DEBOUNCE_CYCLES must be >= 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("button_reader: FIFO_DEPTH must be a power of 2 in 2..16");
    end

    typedef enum logic [1:0] {
        STABLE_LOW,
        CHECK_HIGH,
        STABLE_HIGH,
        CHECK_LOW
    } state_t;

    typedef enum logic [1:0] {
        KIND_PRESS,
        KIND_LONG,
        KIND_RELEASE
    } evt_kind_t;

    // Synchroniser and debounce state
    logic [N_IN-1:0]  sync1;
    logic [N_IN-1:0]  s;
    state_t           state [N_IN];
    logic [CNT_W-1:0] dcnt  [N_IN];

    logic [N_IN-1:0] acc_press;
    logic [N_IN-1:0] acc_release;
    logic [N_IN-1:0] pend_press;
    logic [N_IN-1:0] pend_release;
    logic [N_IN-1:0] clr_press;
    logic [N_IN-1:0] clr_release;
    logic [N_IN-1:0] pend_any;
    logic [N_IN-1:0] lost;

`ifdef BUTTON_READER_LONG_PRESS_EN
    logic [HOLD_W-1:0] hcnt [N_IN];
    logic [N_IN-1:0]   long_done;
    logic [N_IN-1:0]   acc_long;
    logic [N_IN-1:0]   pend_long;
    logic [N_IN-1:0]   clr_long;
`endif

    // Arbiter and FIFO signals
    evt_kind_t          arb_kind;
    logic [2:0]         arb_idx;
    logic               arb_any;
    logic [ENTRY_W-1:0] wr_entry;
    logic               push;
    logic               pop;
    logic               full;
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_next;
    logic [CW-1:0]      count;
    logic [CW-1:0]      visible;

    // An accept fires on the edge where a CHECK state has seen DEBOUNCE_CYCLES steady samples.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave a latch behind.
        acc_press   = '0;
        acc_release = '0;
        for (int i = 0; i < N_IN; i++) begin
            acc_press[i]   = (state[i] == CHECK_HIGH) && s[i]  && (dcnt[i] == DB_LAST);
            acc_release[i] = (state[i] == CHECK_LOW)  && !s[i] && (dcnt[i] == DB_LAST);
        end
    end

`ifdef BUTTON_READER_LONG_PRESS_EN
    always_comb begin
        acc_long = '0;
        for (int i = 0; i < N_IN; i++) begin
            acc_long[i] = (state[i] == STABLE_HIGH) && !long_done[i] && (hcnt[i] == HOLD_LAST);
        end
    end

    assign pend_any = pend_press | pend_release | pend_long;
    assign lost     = (acc_press & pend_press) | (acc_release & pend_release) | (acc_long & pend_long);
`else
    assign pend_any = pend_press | pend_release;
    assign lost     = (acc_press & pend_press) | (acc_release & pend_release);
`endif

    // Per-input synchroniser, debounce FSM and pending press/release flags.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sync1        <= '0;
            s            <= '0;
            btn_state    <= '0;
            pend_press   <= '0;
            pend_release <= '0;
            evt_overflow <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                state[i] <= STABLE_LOW;
                dcnt[i]  <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sync1 <= btn_in;
            s     <= sync1;
            for (int i = 0; i < N_IN; i++) begin
                case (state[i])
                    STABLE_LOW: begin
                        if (s[i]) begin
                            state[i] <= CHECK_HIGH;
                            dcnt[i]  <= '0;
                        end
                    end
                    CHECK_HIGH: begin
                        if (!s[i]) begin
                            state[i] <= STABLE_LOW;
                        end else if (acc_press[i]) begin
                            state[i]     <= STABLE_HIGH;
                            btn_state[i] <= 1'b1;
                        end else begin
                            dcnt[i] <= dcnt[i] + CNT_W'(1);
                        end
                    end
                    STABLE_HIGH: begin
                        if (!s[i]) begin
                            state[i] <= CHECK_LOW;
                            dcnt[i]  <= '0;
                        end
                    end
                    CHECK_LOW: begin
                        if (s[i]) begin
                            state[i] <= STABLE_HIGH;
                        end else if (acc_release[i]) begin
                            state[i]     <= STABLE_LOW;
                            btn_state[i] <= 1'b0;
                        end else begin
                            dcnt[i] <= dcnt[i] + CNT_W'(1);
                        end
                    end
                    default: state[i] <= STABLE_LOW;
                endcase

                // A new event landing on a still-set flag is dropped; the older one is kept.
                if (clr_press[i]) begin
                    pend_press[i] <= 1'b0;
                end else if (acc_press[i]) begin
                    pend_press[i] <= 1'b1;
                end
                if (clr_release[i]) begin
                    pend_release[i] <= 1'b0;
                end else if (acc_release[i]) begin
                    pend_release[i] <= 1'b1;
                end
            end
            if (|lost) begin
                evt_overflow <= 1'b1;
            end
        end
    end

`ifdef BUTTON_READER_LONG_PRESS_EN
    // Hold counter restarts on each accepted press and fires once before the next press.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            long_done <= '0;
            pend_long <= '0;
            for (int i = 0; i < N_IN; i++) begin
                hcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (acc_press[i]) begin
                    hcnt[i]      <= '0;
                    long_done[i] <= 1'b0;
                end else if (state[i] == STABLE_HIGH && !long_done[i]) begin
                    if (acc_long[i]) begin
                        long_done[i] <= 1'b1;
                    end else begin
                        hcnt[i] <= hcnt[i] + HOLD_W'(1);
                    end
                end
                if (clr_long[i]) begin
                    pend_long[i] <= 1'b0;
                end else if (acc_long[i]) begin
                    pend_long[i] <= 1'b1;
                end
            end
        end
    end
`endif

    // Lowest index wins; within an index press beats long beats release.
    always_comb begin
        arb_any  = 1'b0;
        arb_idx  = '0;
        arb_kind = KIND_RELEASE;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (pend_any[i]) begin
                arb_any = 1'b1;
                arb_idx = 3'(i);
                if (pend_press[i]) begin
                    arb_kind = KIND_PRESS;
`ifdef BUTTON_READER_LONG_PRESS_EN
                end else if (pend_long[i]) begin
                    arb_kind = KIND_LONG;
`endif
                end else begin
                    arb_kind = KIND_RELEASE;
                end
            end
        end
    end

    assign pop  = evt_valid & evt_ready;
    assign full = (count == CW'(FIFO_DEPTH));
    assign push = arb_any & (~full | pop);

    always_comb begin
        clr_press   = '0;
        clr_release = '0;
`ifdef BUTTON_READER_LONG_PRESS_EN
        clr_long    = '0;
        wr_entry    = {arb_kind == KIND_LONG, arb_kind != KIND_RELEASE, arb_idx};
`else
        wr_entry    = {arb_kind != KIND_RELEASE, arb_idx};
`endif
        for (int i = 0; i < N_IN; i++) begin
            clr_press[i]   = push && (arb_idx == 3'(i)) && (arb_kind == KIND_PRESS);
            clr_release[i] = push && (arb_idx == 3'(i)) && (arb_kind == KIND_RELEASE);
`ifdef BUTTON_READER_LONG_PRESS_EN
            clr_long[i]    = push && (arb_idx == 3'(i)) && (arb_kind == KIND_LONG);
`endif
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by count, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Output stage reflects the post-pop head but not this edge's push, so a write shows one cycle later.
    assign rd_next = rd_ptr + PTR_W'(pop);
    assign visible = count - CW'(pop);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            evt_valid <= 1'b0;
            evt_code  <= '0;
`ifdef BUTTON_READER_LONG_PRESS_EN
            evt_long  <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_next;
            count     <= count + CW'(push) - CW'(pop);
            evt_valid <= (visible != '0);
            if (visible != '0) begin
                evt_code <= mem[rd_next][3:0];
`ifdef BUTTON_READER_LONG_PRESS_EN
                evt_long <= mem[rd_next][4];
`endif
            end
        end
    end

endmodule

// File: tb/tb_button_reader.sv
// Self-checking bench for button_reader with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
// Long-press scenario is built when BUTTON_READER_LONG_PRESS_EN is defined (LONG_CYCLES=10).
module tb_button_reader;

    localparam int N_IN            = 8;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int FIFO_DEPTH      = 4;

    logic            clk = 1'b0;
    logic            aresetn;
    logic [N_IN-1:0] btn_in;
    logic [N_IN-1:0] btn_state;
    logic            evt_valid;
    logic            evt_ready;
    logic [3:0]      evt_code;
    logic            evt_overflow;
    logic            got_long;

    int vectors     = 0;
    int miscompares = 0;

    // Expected events as {long, code}, in the order the consumer should see them.
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

`ifdef BUTTON_READER_LONG_PRESS_EN
    logic evt_long;
    assign got_long = evt_long;

    button_reader #(
        .N_IN(N_IN), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .LONG_CYCLES(10), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .aresetn(aresetn), .btn_in(btn_in), .btn_state(btn_state),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_long(evt_long), .evt_overflow(evt_overflow)
    );
`else
    assign got_long = 1'b0;

    button_reader #(
        .N_IN(N_IN), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .aresetn(aresetn), .btn_in(btn_in), .btn_state(btn_state),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_overflow(evt_overflow)
    );
`endif

    // Scoreboard: every accepted event is popped from the queue and compared.
    always @(negedge clk) begin
        if (aresetn && evt_valid && evt_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL event_unexpected: got long=%b code=%b, expected no event", got_long, evt_code);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if ({got_long, evt_code} !== e) begin
                    miscompares++;
                    $display("FAIL event_code: got long=%b code=%b, expected long=%b code=%b",
                             got_long, evt_code, e[4], e[3:0]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drained(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || evt_valid) && n < budget) begin
            step(1);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0 || evt_valid) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d events still outstanding, evt_valid=%b after %0d cycles",
                     exp_q.size(), evt_valid, n);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        aresetn   = 1'b0;
        btn_in    = '0;
        evt_ready = 1'b0;
        step(3);
        vectors++;
        if ({btn_state, evt_valid, evt_code, evt_overflow} !== 15'b0) begin
            miscompares++;
            $display("FAIL reset_state: got btn_state=%h valid=%b code=%b ovf=%b, expected all zero",
                     btn_state, evt_valid, evt_code, evt_overflow);
        end
        aresetn = 1'b1;
        step(2);
    endtask

    task automatic test_clean_press();
        evt_ready = 1'b0;
        btn_in[2] = 1'b1;
        exp_q.push_back(5'b0_1010);
        for (int k = 0; k <= 8; k++) begin
            step(1);
            if (k == 5) begin
                vectors++;
                if (btn_state !== 8'h00) begin
                    miscompares++;
                    $display("FAIL press_state_early: got %h at T+5, expected 00", btn_state);
                end
            end
            if (k == 6) begin
                vectors++;
                if (btn_state !== 8'h04) begin
                    miscompares++;
                    $display("FAIL press_state_latency: got %h at T+6, expected 04", btn_state);
                end
            end
            if (k == 7) begin
                vectors++;
                if (evt_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL press_valid_early: got %b at T+7, expected 0", evt_valid);
                end
            end
            if (k == 8) begin
                vectors++;
                if (evt_valid !== 1'b1 || evt_code !== 4'b1010) begin
                    miscompares++;
                    $display("FAIL press_valid_latency: got valid=%b code=%b at T+8, expected 1/1010",
                             evt_valid, evt_code);
                end
            end
        end
        evt_ready = 1'b1;
        step(1);
        vectors++;
        if (evt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pop_clears_valid: got %b, expected 0", evt_valid);
        end
        btn_in[2] = 1'b0;
        exp_q.push_back(5'b0_0010);
        wait_drained(40);
        vectors++;
        if (btn_state !== 8'h00) begin
            miscompares++;
            $display("FAIL release_state: got %h, expected 00", btn_state);
        end
    endtask

    task automatic test_bounce();
        evt_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            btn_in[0] = (c < 20) && ((c / 2) % 2 == 0);
            step(1);
            vectors++;
            if (btn_state[0] !== 1'b0 || evt_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL bounce_cycle%0d: got state=%b valid=%b, expected 0/0", c, btn_state[0], evt_valid);
            end
        end
    endtask

    task automatic test_simultaneous();
        int n = 0;
        evt_ready = 1'b1;
        btn_in[5] = 1'b1;
        btn_in[1] = 1'b1;
        exp_q.push_back(5'b0_1001);
        exp_q.push_back(5'b0_1101);
        while (!evt_valid && n < 20) begin
            step(1);
            n++;
        end
        vectors++;
        if (evt_valid !== 1'b1 || evt_code !== 4'b1001) begin
            miscompares++;
            $display("FAIL simul_first: got valid=%b code=%b, expected 1/1001", evt_valid, evt_code);
        end
        step(1);
        vectors++;
        if (evt_valid !== 1'b1 || evt_code !== 4'b1101) begin
            miscompares++;
            $display("FAIL simul_second: got valid=%b code=%b, expected 1/1101", evt_valid, evt_code);
        end
        btn_in[5] = 1'b0;
        btn_in[1] = 1'b0;
        exp_q.push_back(5'b0_0001);
        exp_q.push_back(5'b0_0101);
        wait_drained(40);
    endtask

    task automatic test_backpressure();
        evt_ready = 1'b0;
        // First press fills the FIFO with press 0..3; everything after that waits in pending flags.
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 1'b1, 3'(i)});
        for (int ph = 0; ph < 4; ph++) begin
            btn_in[3:0] = (ph % 2 == 0) ? 4'hF : 4'h0;
            for (int c = 0; c < 12; c++) begin
                step(1);
                if (ph > 0) begin
                    vectors++;
                    if (evt_valid !== 1'b1 || evt_code !== 4'b1000) begin
                        miscompares++;
                        $display("FAIL bp_head_stable ph%0d c%0d: got valid=%b code=%b, expected 1/1000",
                                 ph, c, evt_valid, evt_code);
                    end
                end
            end
            if (ph == 2) begin
                vectors++;
                if (evt_overflow !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_overflow_early: got %b, expected 0", evt_overflow);
                end
            end
        end
        vectors++;
        if (evt_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_overflow_set: got %b, expected 1", evt_overflow);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, 1'b1, 3'(i)});
            exp_q.push_back({1'b0, 1'b0, 3'(i)});
        end
        evt_ready = 1'b1;
        wait_drained(80);
        vectors++;
        if (btn_state !== 8'h00 || evt_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_after_drain: got state=%h ovf=%b, expected 00/1", btn_state, evt_overflow);
        end
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b0;
        btn_in[7:6] = 2'b11;
        step(12);
        vectors++;
        if (evt_valid !== 1'b1 || evt_code !== 4'b1110) begin
            miscompares++;
            $display("FAIL rst_queued: got valid=%b code=%b, expected 1/1110", evt_valid, evt_code);
        end
        btn_in[4] = 1'b1;
        step(4);
        #3;
        aresetn = 1'b0;
        #1;
        vectors++;
        if (evt_valid !== 1'b0 || btn_state !== 8'h00 || evt_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_immediate: got valid=%b state=%h ovf=%b, expected 0/00/0",
                     evt_valid, btn_state, evt_overflow);
        end
        btn_in = '0;
        step(2);
        aresetn   = 1'b1;
        evt_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1);
            vectors++;
            if (evt_valid !== 1'b0 || btn_state !== 8'h00) begin
                miscompares++;
                $display("FAIL rst_no_event c%0d: got valid=%b state=%h, expected 0/00", c, evt_valid, btn_state);
            end
        end
    endtask

`ifdef BUTTON_READER_LONG_PRESS_EN
    task automatic test_long_press();
        evt_ready = 1'b1;
        btn_in[3] = 1'b1;
        exp_q.push_back(5'b0_1011);
        exp_q.push_back(5'b1_1011);
        step(40);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL long_events: got %0d of 2 expected events while held", 2 - exp_q.size());
        end
        btn_in[3] = 1'b0;
        exp_q.push_back(5'b0_0011);
        wait_drained(40);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_backpressure();
        test_reset_mid();
`ifdef BUTTON_READER_LONG_PRESS_EN
        test_long_press();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
